// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared encodings and constants for the multiply/divide unit
package muldiv_unit_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FIXUP = 2'b10,
    ST_DONE  = 2'b11
  } md_state_e;

  // One iteration retires one multiplier bit or one quotient bit.
  function automatic int md_iter_count(input int width);
    return width;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational shift-add / restoring shift-subtract iteration
module muldiv_step
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Multiply: acc = {partial, multiplier}; add when lsb set, then shift right with carry.
  // Divide:   acc = {remainder, dividend/quotient}; shift left, keep difference if it fits.
  always_comb begin
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opb_i} : '0);
    rem_sh  = acc_i[2*WIDTH-1:WIDTH-1];
    trial   = rem_sh - {1'b0, opb_i};
    acc_o   = {mul_sum, acc_i[WIDTH-1:1]};
    if (is_div_i) begin
      if (!trial[WIDTH]) begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MIPS-style multiply/divide unit with HI/LO registers
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WE_HI,
  input  logic             WE_LO,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done
);

  localparam int ITERS = md_iter_count(WIDTH);
  localparam int CNT_W = $clog2(ITERS + 1);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opb_q;
  logic               is_div_q;
  logic               neg_lo_q;
  logic               neg_hi_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               idle_like;
  logic               start_ok;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               cap_neg_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (acc_step)
  );

  // Operand capture: magnitudes plus the sign corrections FIXUP will need.
  always_comb begin
    idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    start_ok  = Start && idle_like;
    is_signed = (Op == OP_MULT) || (Op == OP_DIV);
    a_neg     = is_signed && A[WIDTH-1];
    b_neg     = is_signed && B[WIDTH-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    // A zero divisor keeps the all-ones quotient un-negated.
    cap_neg_lo = (a_neg ^ b_neg) && !(Op[1] && (B == '0));
  end

  // Sign fixup of the magnitude result.
  always_comb begin
    prod   = neg_lo_q ? -acc_q : acc_q;
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (is_div_q) begin
      hi_res = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      lo_res = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
  end

  // Control FSM with iteration counter, accumulator and registered Busy/Done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITERS - 1)) begin
            state_q <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          done_q <= 1'b0;
          if (start_ok) begin
            state_q  <= ST_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= {{WIDTH{1'b0}}, a_mag};
            opb_q    <= b_mag;
            is_div_q <= Op[1];
            neg_lo_q <= cap_neg_lo;
            neg_hi_q <= (Op == OP_DIV) && A[WIDTH-1];
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // HI/LO: result at the end of FIXUP, direct writes only while not busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == ST_FIXUP) begin
      hi_q <= hi_res;
      lo_q <= lo_res;
    end else if (idle_like) begin
      if (WE_HI) hi_q <= WD;
      if (WE_LO) lo_q <= WD;
    end
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule
